// File: rtl/encrypt_pipe_pkg.sv
`default_nettype none
// ============================================================================
// encrypt_pipe_pkg : shared constants, types and rotation helper of the
//                    shift-cipher back end.
// Revision         : 1.0
// ============================================================================
package encrypt_pipe_pkg;

  localparam int         ALPHA_LEN        = 26;
  localparam logic [7:0] ASCII_UPPER_BASE = 8'd65;
  localparam logic [7:0] ASCII_LOWER_BASE = 8'd97;
  localparam logic [7:0] ASCII_ERR        = 8'h3F;

  typedef logic [25:0] onehot_t;
  typedef logic [4:0]  alpha_idx_t;

  // Forward rotation; amt must be 0..25. An amt of 0 shifts the wrapped part fully out.
  function automatic onehot_t rotate_fwd(input onehot_t vec, input alpha_idx_t amt);
    return (vec << amt) | (vec >> (5'(ALPHA_LEN) - amt));
  endfunction

endpackage
`default_nettype wire

// File: rtl/encrypt_pipe_shift_rot_dec_enc.sv
`default_nettype none
// ============================================================================
// onehot26_encoder : combinational 26-bit one-hot to index encoder with an
//                    exactly-one-bit-set valid flag.
// Revision         : 1.0
// ============================================================================
module onehot26_encoder
  import encrypt_pipe_pkg::*;
(
  input  onehot_t    i_onehot,
  output alpha_idx_t o_idx,
  output logic       o_valid
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < ALPHA_LEN; i++) begin
      if (i_onehot[i]) begin
        o_idx = o_idx | alpha_idx_t'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign o_valid = (i_onehot != '0) && ((i_onehot & (i_onehot - 26'd1)) == '0);

endmodule
`default_nettype wire

// File: rtl/encrypt_pipe_shift_rot_dec.sv
`default_nettype none
// ============================================================================
// encrypt_pipe_shift_rot_dec : two-stage rotate/decode back end of the shift
//                              cipher with a per-stream key schedule.
// Revision                   : 1.0
// ============================================================================
module encrypt_pipe_shift_rot_dec
  import encrypt_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  input  logic        is_alpha_upper_case_in,
  input  logic        is_alpha_low_case_in,
  input  logic [31:0] extended_shift_data_in,
  input  logic        shift_en,
  input  logic [3:0]  shift_amt,
  input  logic [2:0]  rot_freq,
  input  logic        mode,
  input  logic        clr,
  output logic        en_out,
  output logic [7:0]  dout,
  output logic        err_out,
  output logic [4:0]  key_offset_out
);

  localparam logic [5:0] c_alpha_len = 6'(ALPHA_LEN);
  localparam logic [4:0] c_last_idx  = 5'(ALPHA_LEN - 1);

  logic       w_is_letter;
  logic [5:0] w_sum;
  logic [5:0] w_sum_wrap;
  alpha_idx_t w_shift;
  alpha_idx_t w_rot_amt;
  onehot_t    w_rotated;
  logic       w_unused_bits;

  logic [2:0] r_char_cnt;
  alpha_idx_t r_offset;

  logic       r_a_en;
  logic       r_a_letter;
  logic       r_a_upper;
  logic [7:0] r_a_byte;
  onehot_t    r_a_vec;

  alpha_idx_t w_idx;
  logic       w_valid;
  logic [7:0] w_dout;
  logic       w_err;

  assign w_is_letter = en_in & shift_en & (is_alpha_upper_case_in ^ is_alpha_low_case_in);

  // Sum peaks at 15 + 25 = 40, so one conditional subtract reduces it mod 26.
  assign w_sum      = {2'b00, shift_amt} + {1'b0, r_offset};
  assign w_sum_wrap = (w_sum >= c_alpha_len) ? (w_sum - c_alpha_len) : w_sum;
  assign w_shift    = w_sum_wrap[4:0];
  assign w_rot_amt  = mode ? w_shift
                           : ((w_shift == '0) ? '0 : (c_alpha_len[4:0] - w_shift));
  assign w_rotated  = rotate_fwd(extended_shift_data_in[25:0], w_rot_amt);

  assign w_unused_bits = ^extended_shift_data_in[31:26];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_char_cnt <= '0;
      r_offset   <= '0;
    end else if (clr) begin
      r_char_cnt <= '0;
      r_offset   <= '0;
    end else if (w_is_letter && (rot_freq != 3'd0)) begin
      // >= keeps the schedule stepping if rot_freq shrinks below the current count.
      if (r_char_cnt >= (rot_freq - 3'd1)) begin
        r_char_cnt <= '0;
        r_offset   <= (r_offset == c_last_idx) ? '0 : (r_offset + 5'd1);
      end else begin
        r_char_cnt <= r_char_cnt + 3'd1;
      end
    end
  end

  assign key_offset_out = r_offset;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_en     <= 1'b0;
      r_a_letter <= 1'b0;
      r_a_upper  <= 1'b0;
      r_a_byte   <= '0;
      r_a_vec    <= '0;
    end else begin
      r_a_en     <= en_in;
      r_a_letter <= w_is_letter;
      r_a_upper  <= is_alpha_upper_case_in;
      r_a_byte   <= en_in ? extended_shift_data_in[7:0] : 8'h00;
      r_a_vec    <= w_is_letter ? w_rotated : '0;
    end
  end

  onehot26_encoder u_enc (
    .i_onehot (r_a_vec),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  always_comb begin
    w_dout = 8'h00;
    w_err  = 1'b0;
    if (r_a_en) begin
      if (!r_a_letter) begin
        w_dout = r_a_byte;
      end else if (!w_valid) begin
        w_dout = ASCII_ERR;
        w_err  = 1'b1;
      end else begin
        w_dout = (r_a_upper ? ASCII_UPPER_BASE : ASCII_LOWER_BASE) + {3'b000, w_idx};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_out  <= 1'b0;
      dout    <= 8'h00;
      err_out <= 1'b0;
    end else begin
      en_out  <= r_a_en;
      dout    <= w_dout;
      err_out <= w_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_encrypt_pipe_shift_rot_dec.sv
`default_nettype none
// ============================================================================
// tb_encrypt_pipe_shift_rot_dec : table vectors, corner sequences and a
//                                 randomized letter-arithmetic reference model.
// Revision                      : 1.0
// ============================================================================
module tb_encrypt_pipe_shift_rot_dec;

  typedef struct {
    logic        en;
    logic        up;
    logic        lo;
    logic [31:0] data;
    logic        sen;
    logic [3:0]  amt;
    logic [2:0]  rf;
    logic        md;
    logic        clr;
  } in_t;

  typedef struct {
    logic       en;
    logic [7:0] dout;
    logic       err;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en_in;
  logic        up_in;
  logic        lo_in;
  logic [31:0] data_in;
  logic        shift_en;
  logic [3:0]  shift_amt;
  logic [2:0]  rot_freq;
  logic        mode;
  logic        clr;
  logic        en_out;
  logic [7:0]  dout;
  logic        err_out;
  logic [4:0]  key_offset_out;

  int   nvec;
  int   nfail;
  int   m_off;
  int   m_cnt;
  out_t pipe[$];
  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  encrypt_pipe_shift_rot_dec dut (
    .clk                    (clk),
    .rst                    (rst),
    .en_in                  (en_in),
    .is_alpha_upper_case_in (up_in),
    .is_alpha_low_case_in   (lo_in),
    .extended_shift_data_in (data_in),
    .shift_en               (shift_en),
    .shift_amt              (shift_amt),
    .rot_freq               (rot_freq),
    .mode                   (mode),
    .clr                    (clr),
    .en_out                 (en_out),
    .dout                   (dout),
    .err_out                (err_out),
    .key_offset_out         (key_offset_out)
  );

  function automatic in_t ci(input int en, input int up, input int lo, input logic [31:0] data,
                             input int sen, input int amt, input int rf, input int md, input int c);
    in_t v;
    v.en   = (en != 0);
    v.up   = (up != 0);
    v.lo   = (lo != 0);
    v.data = data;
    v.sen  = (sen != 0);
    v.amt  = 4'(amt);
    v.rf   = 3'(rf);
    v.md   = (md != 0);
    v.clr  = (c != 0);
    return v;
  endfunction

  function automatic out_t co(input int en, input int d, input int err);
    out_t o;
    o.en   = (en != 0);
    o.dout = 8'(d);
    o.err  = (err != 0);
    return o;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t t;
    t.i = i;
    t.o = o;
    tbl.push_back(t);
  endtask

  // Reference: work on letter indices with modular arithmetic, not bit vectors.
  function automatic out_t model_out(input in_t v, input int off);
    out_t o;
    int   idx;
    int   s;
    o = co(0, 0, 0);
    if (!v.en) return o;
    o.en = 1'b1;
    if (v.sen && (v.up != v.lo)) begin
      if ($countones(v.data[25:0]) != 1) begin
        o.dout = 8'h3F;
        o.err  = 1'b1;
      end else begin
        idx = 0;
        for (int i = 0; i < 26; i++) if (v.data[i]) idx = i;
        s   = (int'(v.amt) + off) % 26;
        idx = v.md ? (idx + s) % 26 : (idx - s + 26) % 26;
        o.dout = 8'((v.up ? 65 : 97) + idx);
      end
    end else begin
      o.dout = v.data[7:0];
    end
    return o;
  endfunction

  task automatic model_sched(input in_t v);
    if (v.clr) begin
      m_off = 0;
      m_cnt = 0;
    end else if (v.en && v.sen && (v.up != v.lo) && (v.rf != 0)) begin
      m_cnt++;
      if (m_cnt >= int'(v.rf)) begin
        m_cnt = 0;
        m_off = (m_off + 1) % 26;
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic chk_out(input string name, input out_t e);
    nvec++;
    if ({en_out, dout, err_out} !== {e.en, e.dout, e.err}) begin
      nfail++;
      $display("FAIL %s: got en=%b dout=%02h err=%b, want en=%b dout=%02h err=%b",
               name, en_out, dout, err_out, e.en, e.dout, e.err);
    end
  endtask

  task automatic drive(input in_t v);
    en_in     = v.en;
    up_in     = v.up;
    lo_in     = v.lo;
    data_in   = v.data;
    shift_en  = v.sen;
    shift_amt = v.amt;
    rot_freq  = v.rf;
    mode      = v.md;
    clr       = v.clr;
  endtask

  // Entered and left on a falling edge; the output seen is the character from the previous step.
  task automatic step(input in_t v, input bit use_exp, input out_t want, input string name);
    out_t e;
    drive(v);
    e = use_exp ? want : model_out(v, m_off);
    model_sched(v);
    pipe.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = pipe.pop_front();
    chk_out(name, e);
    chk($sformatf("%s_koff", name), int'(key_offset_out), m_off);
  endtask

  task automatic model_reset();
    m_off = 0;
    m_cnt = 0;
    pipe.delete();
    pipe.push_back(co(0, 0, 0));
  endtask

  initial begin
    in_t        v;
    in_t        idle;
    out_t       none;
    logic [2:0] rf_cur;
    int         r;

    nvec  = 0;
    nfail = 0;
    none  = co(0, 0, 0);
    idle  = ci(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);

    add(ci(1, 1, 0, 32'h0000_0001, 1, 3, 0, 1, 0), co(1, 8'h44, 0));
    add(ci(1, 0, 1, 32'h0200_0000, 1, 3, 0, 1, 0), co(1, 8'h63, 0));
    add(ci(1, 0, 1, 32'h0000_0004, 1, 3, 0, 0, 0), co(1, 8'h7A, 0));
    add(ci(1, 1, 0, 32'h0000_0003, 1, 3, 0, 1, 0), co(1, 8'h3F, 1));
    add(ci(1, 1, 0, 32'h0000_0041, 0, 3, 0, 1, 0), co(1, 8'h41, 0));
    add(ci(1, 0, 0, 32'h0000_0020, 1, 3, 0, 1, 0), co(1, 8'h20, 0));
    add(ci(1, 1, 1, 32'h0000_015A, 1, 3, 0, 1, 0), co(1, 8'h5A, 0));
    add(ci(0, 1, 0, 32'h0000_0004, 1, 3, 0, 1, 0), co(0, 8'h00, 0));
    add(ci(1, 1, 0, 32'h0000_0000, 1, 3, 0, 1, 0), co(1, 8'h3F, 1));
    add(ci(1, 1, 0, 32'h0200_0000, 1, 0, 0, 0, 0), co(1, 8'h5A, 0));
    add(ci(1, 0, 1, 32'h0000_0001, 1, 15, 0, 0, 0), co(1, 8'h6C, 0));
    add(ci(1, 0, 1, 32'h0100_0000, 1, 15, 0, 1, 0), co(1, 8'h6E, 0));
    add(ci(1, 0, 1, 32'h0000_0111, 1, 5, 0, 0, 0), co(1, 8'h3F, 1));

    drive(idle);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en_out", int'(en_out), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_err_out", int'(err_out), 0);
    chk("rst_koff", int'(key_offset_out), 0);
    rst = 1'b1;
    model_reset();

    foreach (tbl[k]) step(tbl[k].i, 1'b1, tbl[k].o, $sformatf("tbl%0d", k));
    step(idle, 1'b0, none, "tbl_drain");

    // Key schedule: two letters per step, the space must not count.
    step(ci(0, 0, 0, 32'h0, 0, 0, 0, 0, 1), 1'b0, none, "sched_clr0");
    step(ci(1, 1, 0, 32'h1, 1, 1, 2, 1, 0), 1'b1, co(1, 8'h42, 0), "sched_A1");
    step(ci(1, 1, 0, 32'h1, 1, 1, 2, 1, 0), 1'b1, co(1, 8'h42, 0), "sched_A2");
    step(ci(1, 0, 0, 32'h20, 1, 1, 2, 1, 0), 1'b1, co(1, 8'h20, 0), "sched_sp");
    step(ci(1, 1, 0, 32'h1, 1, 1, 2, 1, 0), 1'b1, co(1, 8'h43, 0), "sched_A3");
    step(ci(1, 1, 0, 32'h1, 1, 1, 2, 1, 0), 1'b1, co(1, 8'h43, 0), "sched_A4");
    step(idle, 1'b0, none, "sched_d1");
    step(idle, 1'b0, none, "sched_d2");
    chk("sched_koff_end", int'(key_offset_out), 2);
    step(ci(0, 0, 0, 32'h0, 0, 0, 0, 0, 1), 1'b0, none, "sched_clr1");
    chk("sched_koff_clr", int'(key_offset_out), 0);

    // Bypass leaves the schedule alone even with rot_freq set.
    step(ci(1, 1, 0, 32'h41, 0, 2, 1, 1, 0), 1'b0, none, "byp");
    step(idle, 1'b0, none, "byp_d");
    chk("byp_koff", int'(key_offset_out), 0);

    // Asynchronous reset in the middle of a stream.
    for (int k = 0; k < 5; k++) step(ci(1, 1, 0, 32'h1, 1, 0, 1, 1, 0), 1'b0, none, "pre_rst");
    drive(ci(1, 1, 0, 32'h1, 1, 0, 1, 1, 0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_en_out", int'(en_out), 0);
    chk("async_dout", int'(dout), 0);
    chk("async_err_out", int'(err_out), 0);
    chk("async_koff", int'(key_offset_out), 0);
    drive(idle);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(idle, 1'b0, none, "post_rst");

    rf_cur = 3'd1;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 19) == 0) rf_cur = 3'($urandom_range(0, 7));
      v.en   = ($urandom_range(0, 7) != 0);
      r      = $urandom_range(0, 7);
      v.up   = (r <= 2) || (r == 7);
      v.lo   = ((r >= 3) && (r <= 5)) || (r == 7);
      v.data = ($urandom_range(0, 9) == 0) ? 32'($urandom) : (32'h1 << $urandom_range(0, 25));
      v.sen  = ($urandom_range(0, 9) != 0);
      v.amt  = 4'($urandom_range(0, 15));
      v.rf   = rf_cur;
      v.md   = ($urandom_range(0, 1) != 0);
      v.clr  = ($urandom_range(0, 39) == 0);
      step(v, 1'b0, none, $sformatf("rnd%0d", n));
    end
    step(idle, 1'b0, none, "rnd_d1");
    step(idle, 1'b0, none, "rnd_d2");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
